// File: rtl/pipeline_fwd_chain.sv
// Post-decode pipeline control chain: per-stage metadata, operand forwarding, load-use stall, writeback.
// Forwarding is combinational; stall holds stage 1 and bubbles stage 2; hold freezes every stage.
module pipeline_fwd_chain #(
  parameter int STAGES   = 4,
  parameter int LD_STAGE = 4,
  parameter int DATA_W   = 16,
  parameter int REGN_W   = 3,
  parameter int CTRL_W   = 22
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [REGN_W-1:0]        in_wnum,
  input  logic                     in_write,
  input  logic                     in_loads,
  input  logic [REGN_W-1:0]        src_num_a,
  input  logic [REGN_W-1:0]        src_num_b,
  input  logic [REGN_W-1:0]        src_num_c,
  input  logic [DATA_W-1:0]        rf_data_a,
  input  logic [DATA_W-1:0]        rf_data_b,
  input  logic [DATA_W-1:0]        rf_data_c,
  input  logic [DATA_W-1:0]        ex_result,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     hold,
  input  logic                     flush,
  output logic [DATA_W-1:0]        fwd_a,
  output logic [DATA_W-1:0]        fwd_b,
  output logic [DATA_W-1:0]        fwd_c,
  output logic                     stall,
  output logic [STAGES*CTRL_W-1:0] ctrl_out,
  output logic [STAGES-1:0]        valid_out,
  output logic                     wb_write,
  output logic [REGN_W-1:0]        wb_num,
  output logic [DATA_W-1:0]        wb_data
);

  logic              vld_q  [1:STAGES];
  logic [CTRL_W-1:0] ctrl_q [1:STAGES];
  logic [REGN_W-1:0] wnum_q [1:STAGES];
  logic              wr_q   [1:STAGES];
  logic              ld_q   [1:STAGES];
  logic [DATA_W-1:0] res_q  [3:STAGES];

  logic [DATA_W-1:0] eff    [2:STAGES];
  logic              avail  [2:STAGES];
  logic              blk_a, blk_b, blk_c;

  // Stage 2 result comes straight from the ALU; stage 1 carries no result at all.
  for (genvar g = 2; g <= STAGES; g++) begin : g_eff
    if (g == 2) begin : g_ex
      assign eff[g]   = ex_result;
      assign avail[g] = !ld_q[g];
    end else if (g == LD_STAGE) begin : g_ld
      assign eff[g]   = ld_q[g] ? mem_rdata : res_q[g];
      assign avail[g] = 1'b1;
    end else begin : g_lat
      assign eff[g]   = res_q[g];
      assign avail[g] = (g > LD_STAGE) || !ld_q[g];
    end
  end

  always_comb begin
    fwd_a = rf_data_a;
    fwd_b = rf_data_b;
    fwd_c = rf_data_c;
    blk_a = 1'b0;
    blk_b = 1'b0;
    blk_c = 1'b0;
    // Walk oldest to youngest so the youngest matching producer has the last word.
    for (int s = STAGES; s >= 2; s--) begin
      if (vld_q[s] && wr_q[s]) begin
        if (wnum_q[s] == src_num_a) begin
          fwd_a = eff[s];
          blk_a = !avail[s];
        end
        if (wnum_q[s] == src_num_b) begin
          fwd_b = eff[s];
          blk_b = !avail[s];
        end
        if (wnum_q[s] == src_num_c) begin
          fwd_c = eff[s];
          blk_c = !avail[s];
        end
      end
    end
  end

  assign stall = vld_q[1] && (blk_a || blk_b || blk_c);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 1; s <= STAGES; s++) begin
        vld_q[s]  <= 1'b0;
        ctrl_q[s] <= '0;
        wnum_q[s] <= '0;
        wr_q[s]   <= 1'b0;
        ld_q[s]   <= 1'b0;
      end
      for (int s = 3; s <= STAGES; s++) begin
        res_q[s] <= '0;
      end
    end else if (!hold) begin
      for (int s = STAGES; s >= 3; s--) begin
        vld_q[s]  <= vld_q[s-1];
        ctrl_q[s] <= ctrl_q[s-1];
        wnum_q[s] <= wnum_q[s-1];
        wr_q[s]   <= wr_q[s-1];
        ld_q[s]   <= ld_q[s-1];
        res_q[s]  <= eff[s-1];
      end

      if (flush || stall) begin
        vld_q[2]  <= 1'b0;
        ctrl_q[2] <= '0;
        wnum_q[2] <= '0;
        wr_q[2]   <= 1'b0;
        ld_q[2]   <= 1'b0;
      end else begin
        vld_q[2]  <= vld_q[1];
        ctrl_q[2] <= ctrl_q[1];
        wnum_q[2] <= wnum_q[1];
        wr_q[2]   <= wr_q[1];
        ld_q[2]   <= ld_q[1];
      end

      // Flush outranks stall: the redirect kills the instruction stall was protecting.
      if (flush) begin
        vld_q[1]  <= 1'b0;
        ctrl_q[1] <= '0;
        wnum_q[1] <= '0;
        wr_q[1]   <= 1'b0;
        ld_q[1]   <= 1'b0;
      end else if (!stall) begin
        vld_q[1]  <= in_valid;
        ctrl_q[1] <= in_ctrl;
        wnum_q[1] <= in_wnum;
        wr_q[1]   <= in_write;
        ld_q[1]   <= in_loads;
      end
    end
  end

  for (genvar g = 1; g <= STAGES; g++) begin : g_out
    assign valid_out[g-1]                  = vld_q[g];
    assign ctrl_out[(g-1)*CTRL_W +: CTRL_W] = ctrl_q[g];
  end

  assign wb_write = vld_q[STAGES] && wr_q[STAGES] && !hold;
  assign wb_num   = wnum_q[STAGES];
  assign wb_data  = eff[STAGES];

endmodule

// File: tb/tb_pipeline_fwd_chain.sv
// Bench for pipeline_fwd_chain: every instruction carries the value it will produce; a scoreboard
// checks forwarding, stalls, bubbles and writeback against an instruction-level model.
module tb_pipeline_fwd_chain;
  localparam int S  = 4;
  localparam int LD = 4;
  localparam int DW = 16;
  localparam int RW = 3;
  localparam int CW = 22;

  typedef logic [87:0] w_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            in_valid;
  logic [CW-1:0]   in_ctrl;
  logic [RW-1:0]   in_wnum;
  logic            in_write;
  logic            in_loads;
  logic [RW-1:0]   src_num_a, src_num_b, src_num_c;
  logic [DW-1:0]   rf_data_a, rf_data_b, rf_data_c;
  logic [DW-1:0]   ex_result, mem_rdata;
  logic            hold, flush;
  logic [DW-1:0]   fwd_a, fwd_b, fwd_c;
  logic            stall;
  logic [S*CW-1:0] ctrl_out;
  logic [S-1:0]    valid_out;
  logic            wb_write;
  logic [RW-1:0]   wb_num;
  logic [DW-1:0]   wb_data;

  pipeline_fwd_chain #(
    .STAGES(S), .LD_STAGE(LD), .DATA_W(DW), .REGN_W(RW), .CTRL_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ctrl(in_ctrl), .in_wnum(in_wnum),
    .in_write(in_write), .in_loads(in_loads),
    .src_num_a(src_num_a), .src_num_b(src_num_b), .src_num_c(src_num_c),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b), .rf_data_c(rf_data_c),
    .ex_result(ex_result), .mem_rdata(mem_rdata),
    .hold(hold), .flush(flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c),
    .stall(stall), .ctrl_out(ctrl_out), .valid_out(valid_out),
    .wb_write(wb_write), .wb_num(wb_num), .wb_data(wb_data)
  );

  // One in-flight instruction; val is the value it produces (ALU result or load data).
  typedef struct {
    logic          vld;
    logic [CW-1:0] ctrl;
    logic [RW-1:0] wnum;
    logic          wr;
    logic          ld;
    logic [DW-1:0] val;
    logic [RW-1:0] sa, sb, sc;
  } ins_t;

  typedef struct {
    logic [S-1:0]  vout;
    logic          stl;
    logic          wbw;
    logic          wbchk;
    logic [RW-1:0] wbn;
    logic [DW-1:0] wbd;
    logic [DW-1:0] fa, fb, fc;
    logic          ka, kb, kc;
    w_t            ctl, cmask;
  } exp_t;

  ins_t pipe   [1:S];
  ins_t pipe_n [1:S];
  ins_t nxt;
  exp_t sb_q [$];
  exp_t me;
  logic acc_n, auto_gen, rf_fixed;
  int   total = 0;
  int   bad   = 0;

  function automatic ins_t mk(input logic v, input logic [RW-1:0] wn, input logic w,
                              input logic l, input logic [DW-1:0] val,
                              input logic [RW-1:0] a, input logic [RW-1:0] b,
                              input logic [RW-1:0] c);
    ins_t i;
    logic [31:0] r;
    r      = $urandom();
    i.vld  = v;
    i.ctrl = r[CW-1:0];
    i.wnum = wn;
    i.wr   = w;
    i.ld   = l;
    i.val  = val;
    i.sa   = a;
    i.sb   = b;
    i.sc   = c;
    return i;
  endfunction

  function automatic ins_t rnd_ins();
    logic [31:0] r, r2;
    r  = $urandom();
    r2 = $urandom();
    return mk(r[2:0] != 3'd0, r[5:3], r[7:6] != 2'd0, r[9:8] == 2'd0, r[25:10],
              r[28:26], r2[2:0], r2[5:3]);
  endfunction

  function automatic ins_t idle_ins();
    logic [31:0] r, r2;
    r  = $urandom();
    r2 = $urandom();
    return mk(1'b0, r[5:3], r[6], r[7], r[23:8], r[26:24], r[29:27], r2[2:0]);
  endfunction

  function automatic ins_t bub_ins();
    return mk(1'b0, 3'd0, 1'b0, 1'b0, 16'd0, 3'd0, 3'd0, 3'd0);
  endfunction

  // Most recent older writer of src wins; a load not yet at LD has no value to give.
  task automatic resolve(input logic [RW-1:0] src, output logic [DW-1:0] v,
                         output logic blocked, output logic hit);
    hit = 1'b0; blocked = 1'b0; v = '0;
    for (int s = 2; s <= S; s++) begin
      if (!hit && pipe[s].vld && pipe[s].wr && pipe[s].wnum == src) begin
        hit     = 1'b1;
        v       = pipe[s].val;
        blocked = pipe[s].ld && (s < LD);
      end
    end
  endtask

  task automatic chk(input string nm, input w_t act, input w_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic f);
    logic [31:0]   r;
    exp_t          e;
    logic [DW-1:0] v;
    logic          k, hit;
    in_valid  = nxt.vld;
    in_ctrl   = nxt.ctrl;
    in_wnum   = nxt.wnum;
    in_write  = nxt.wr;
    in_loads  = nxt.ld;
    src_num_a = pipe[1].sa;
    src_num_b = pipe[1].sb;
    src_num_c = pipe[1].sc;
    if (!rf_fixed) begin
      r = $urandom();
      rf_data_a = r[15:0];
      rf_data_b = r[31:16];
      r = $urandom();
      rf_data_c = r[15:0];
    end
    r = $urandom();
    ex_result = (pipe[2].vld && !pipe[2].ld) ? pipe[2].val : r[15:0];
    mem_rdata = (pipe[LD].vld && pipe[LD].ld) ? pipe[LD].val : r[31:16];
    hold  = h;
    flush = f;

    resolve(pipe[1].sa, v, k, hit); e.fa = hit ? v : rf_data_a; e.ka = !k;
    resolve(pipe[1].sb, v, k, hit); e.fb = hit ? v : rf_data_b; e.kb = !k;
    resolve(pipe[1].sc, v, k, hit); e.fc = hit ? v : rf_data_c; e.kc = !k;
    e.stl   = pipe[1].vld && (!e.ka || !e.kb || !e.kc);
    e.wbchk = pipe[S].vld && pipe[S].wr;
    e.wbw   = e.wbchk && !h;
    e.wbn   = pipe[S].wnum;
    e.wbd   = pipe[S].val;
    e.ctl   = '0;
    e.cmask = '0;
    for (int s = 1; s <= S; s++) begin
      e.vout[s-1] = pipe[s].vld;
      if (pipe[s].vld) begin
        e.ctl[(s-1)*CW +: CW]   = pipe[s].ctrl;
        e.cmask[(s-1)*CW +: CW] = '1;
      end
    end
    sb_q.push_back(e);

    pipe_n = pipe;
    acc_n  = 1'b0;
    if (!h) begin
      for (int s = S; s >= 3; s--) pipe_n[s] = pipe[s-1];
      if (f) begin
        pipe_n[2] = bub_ins();
        pipe_n[1] = bub_ins();
      end else if (e.stl) begin
        pipe_n[2] = bub_ins();
      end else begin
        pipe_n[2] = pipe[1];
        pipe_n[1] = nxt;
        acc_n     = 1'b1;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    pipe = pipe_n;
    if (acc_n) nxt = auto_gen ? rnd_ins() : idle_ins();
    acc_n = 1'b0;
  endtask

  task automatic cyc(input logic h, input logic f);
    drive(h, f);
    advance();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      me = sb_q.pop_front();
      chk("valid_out", w_t'(valid_out), w_t'(me.vout));
      chk("stall", w_t'(stall), w_t'(me.stl));
      chk("wb_write", w_t'(wb_write), w_t'(me.wbw));
      chk("ctrl_out", w_t'(ctrl_out & me.cmask), me.ctl);
      if (me.wbchk) begin
        chk("wb_num", w_t'(wb_num), w_t'(me.wbn));
        chk("wb_data", w_t'(wb_data), w_t'(me.wbd));
      end
      if (me.ka) chk("fwd_a", w_t'(fwd_a), w_t'(me.fa));
      if (me.kb) chk("fwd_b", w_t'(fwd_b), w_t'(me.fb));
      if (me.kc) chk("fwd_c", w_t'(fwd_c), w_t'(me.fc));
    end
  end

  initial begin
    int          nst;
    logic        done;
    logic [31:0] r;
    rst = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_wnum = '0; in_write = 1'b0; in_loads = 1'b0;
    src_num_a = '0; src_num_b = '0; src_num_c = '0;
    rf_data_a = '0; rf_data_b = '0; rf_data_c = '0;
    ex_result = '0; mem_rdata = '0; hold = 1'b0; flush = 1'b0;
    for (int s = 1; s <= S; s++) pipe[s] = bub_ins();
    nxt = idle_ins(); auto_gen = 1'b0; rf_fixed = 1'b0; acc_n = 1'b0;

    #3;
    chk("rst_valid", w_t'(valid_out), w_t'(0));
    chk("rst_stall", w_t'(stall), w_t'(0));
    chk("rst_wb_write", w_t'(wb_write), w_t'(0));
    chk("rst_wb_num", w_t'(wb_num), w_t'(0));
    chk("rst_wb_data", w_t'(wb_data), w_t'(0));
    chk("rst_ctrl", w_t'(ctrl_out), w_t'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Reset mid-stream with a load-use stall pending.
    nxt = mk(1'b1, 3'd5, 1'b1, 1'b1, 16'h0777, 3'd0, 3'd0, 3'd0); cyc(1'b0, 1'b0);
    nxt = mk(1'b1, 3'd1, 1'b1, 1'b0, 16'h0001, 3'd5, 3'd0, 3'd0); cyc(1'b0, 1'b0);
    nxt = mk(1'b1, 3'd2, 1'b1, 1'b0, 16'h0002, 3'd0, 3'd0, 3'd0);
    drive(1'b0, 1'b0); #1;
    chk("pre_rst_stall", w_t'(stall), w_t'(1));
    advance();
    rst = 1'b0; #1;
    chk("mid_rst_valid", w_t'(valid_out), w_t'(0));
    chk("mid_rst_wb_write", w_t'(wb_write), w_t'(0));
    chk("mid_rst_stall", w_t'(stall), w_t'(0));
    for (int s = 1; s <= S; s++) pipe[s] = bub_ins();
    nxt = idle_ins(); acc_n = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(2);

    // ALU result forwarded from stage 2.
    nxt = mk(1'b1, 3'd3, 1'b1, 1'b0, 16'h1234, 3'd0, 3'd0, 3'd0); cyc(1'b0, 1'b0);
    nxt = mk(1'b1, 3'd7, 1'b0, 1'b0, 16'h0000, 3'd3, 3'd0, 3'd0); cyc(1'b0, 1'b0);
    rf_fixed = 1'b1; rf_data_a = 16'h0000; rf_data_b = 16'h1111; rf_data_c = 16'h2222;
    drive(1'b0, 1'b0); #1;
    chk("alu_fwd_a", w_t'(fwd_a), w_t'(16'h1234));
    chk("alu_stall", w_t'(stall), w_t'(0));
    advance();
    rf_fixed = 1'b0;
    idle(4);

    // Load-use: two stall cycles with a bubble behind, then the load data forwards.
    nxt = mk(1'b1, 3'd5, 1'b1, 1'b1, 16'hBEEF, 3'd0, 3'd0, 3'd0); cyc(1'b0, 1'b0);
    nxt = mk(1'b1, 3'd6, 1'b1, 1'b0, 16'h0042, 3'd5, 3'd0, 3'd0); cyc(1'b0, 1'b0);
    nst = 0; done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      drive(1'b0, 1'b0); #1;
      if (stall) begin
        nst++;
        if (nst == 2) chk("lu_bubble_vout", w_t'(valid_out), w_t'(4'b0101));
      end else begin
        done = 1'b1;
        chk("lu_fwd_a", w_t'(fwd_a), w_t'(16'hBEEF));
      end
      advance();
    end
    chk("lu_stall_cycles", w_t'(nst), w_t'(2));
    idle(4);

    // Youngest producer wins.
    nxt = mk(1'b1, 3'd2, 1'b1, 1'b0, 16'h0001, 3'd0, 3'd0, 3'd0); cyc(1'b0, 1'b0);
    nxt = mk(1'b1, 3'd2, 1'b1, 1'b0, 16'h0002, 3'd0, 3'd0, 3'd0); cyc(1'b0, 1'b0);
    nxt = mk(1'b1, 3'd4, 1'b0, 1'b0, 16'h0000, 3'd0, 3'd2, 3'd0); cyc(1'b0, 1'b0);
    drive(1'b0, 1'b0); #1;
    chk("young_fwd_b", w_t'(fwd_b), w_t'(16'h0002));
    advance();
    idle(4);

    // Flush with two in flight, then a three-cycle hold over a pending writeback.
    nxt = mk(1'b1, 3'd1, 1'b1, 1'b0, 16'h00A1, 3'd0, 3'd0, 3'd0); cyc(1'b0, 1'b0);
    nxt = mk(1'b1, 3'd4, 1'b0, 1'b0, 16'h00A2, 3'd0, 3'd0, 3'd0); cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("flush_vout", w_t'(valid_out), w_t'(4'b0100));
    cyc(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0); #1;
      chk("hold_wb_write", w_t'(wb_write), w_t'(0));
      chk("hold_vout", w_t'(valid_out), w_t'(4'b1000));
      chk("hold_wb_data", w_t'(wb_data), w_t'(16'h00A1));
      advance();
    end
    drive(1'b0, 1'b0); #1;
    chk("unhold_wb_write", w_t'(wb_write), w_t'(1));
    advance();
    idle(4);

    // Non-writing load on the same register: no forward, no stall.
    nxt = mk(1'b1, 3'd6, 1'b0, 1'b1, 16'h0BAD, 3'd0, 3'd0, 3'd0); cyc(1'b0, 1'b0);
    nxt = mk(1'b1, 3'd0, 1'b0, 1'b0, 16'h0000, 3'd0, 3'd0, 3'd6); cyc(1'b0, 1'b0);
    rf_fixed = 1'b1; rf_data_a = 16'h0000; rf_data_b = 16'h0000; rf_data_c = 16'h5A5A;
    drive(1'b0, 1'b0); #1;
    chk("nomatch_fwd_c", w_t'(fwd_c), w_t'(16'h5A5A));
    chk("nomatch_stall", w_t'(stall), w_t'(0));
    advance();
    rf_fixed = 1'b0;

    // Random traffic with occasional hold and flush.
    auto_gen = 1'b1;
    nxt = rnd_ins();
    for (int i = 0; i < 2000; i++) begin
      r = $urandom();
      cyc(r[3:0] == 4'd0, r[7:4] == 4'd0);
    end
    @(negedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
